logic_unit_arbiter: RTL

Shares one combinational bitwise AND/NAND unit between two requesters in the pipeline CPU, such as the decode-issue path and a second issue slot or debug port. Each cycle it grants at most one requester with round-robin arbitration, evaluates the operation, and captures the result with the requester ID in a one-entry output register. The result leaves through a valid/ready response port, so the block sits between issue logic and writeback and absorbs writeback backpressure.

---
 rtl/logic_unit_arbiter_pkg.sv | 9 +
 rtl/logic_unit_arbiter_if.sv | 43 ++++
 rtl/logic_unit_arbiter_core.sv | 19 +
 rtl/logic_unit_arbiter.sv | 78 +++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the two-requester AND/NAND logic unit arbiter.
// Requester IDs double as round-robin priority tokens.
package logic_unit_arbiter_pkg;
    localparam int   LU_WIDTH   = 32;
    localparam logic LU_ID_REQ0 = 1'b0;
    localparam logic LU_ID_REQ1 = 1'b1;
    localparam logic LU_OP_AND  = 1'b0;
    localparam logic LU_OP_NAND = 1'b1;
endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between two issuers, the arbiter and writeback.
// master = requesters plus writeback consumer, slave = arbiter.
interface logic_unit_arbiter_if
    import logic_unit_arbiter_pkg::*;
    #(parameter int WIDTH = LU_WIDTH) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_nand;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_nand;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_carryout;
    logic             rsp_overflow;

    modport master (
        output req0_valid, req0_a, req0_b, req0_nand,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_nand,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_carryout, rsp_overflow,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_nand,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_nand,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_carryout, rsp_overflow,
        input  rsp_ready
    );
endinterface

// File: rtl/logic_unit_arbiter_core.sv
// Combinational bitwise AND/NAND unit: per-bit NAND, then XNOR with the op flag
// so op=0 gives a&b and op=1 gives ~(a&b).
module logic_unit_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             nand_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carryout_o,
    output logic             overflow_o
);
    logic [WIDTH-1:0] nand_bits;

    assign nand_bits  = ~(a_i & b_i);
    assign y_o        = nand_bits ~^ {WIDTH{nand_i}};
    assign carryout_o = 1'b0;
    assign overflow_o = 1'b0;
endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit_core between two requesters,
// with a one-entry valid/ready result register (EMPTY/FULL tracked by rsp_valid_q).
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
    #(parameter int WIDTH = LU_WIDTH) (
    input  logic                  clk,
    input  logic                  reset,
    logic_unit_arbiter_if.slave   bus
);
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_id_q,    rsp_id_d;
    logic             last_grant_q, last_grant_d;

    logic             stage_free;
    logic             gnt0, gnt1, accept;
    logic [WIDTH-1:0] op_a, op_b, unit_y;
    logic             op_nand, unit_co, unit_ov;

    // The result register may be refilled in the same cycle it drains.
    assign stage_free = !rsp_valid_q || bus.rsp_ready;
    assign gnt0 = stage_free && bus.req0_valid &&
                  (!bus.req1_valid || last_grant_q == LU_ID_REQ1);
    assign gnt1 = stage_free && bus.req1_valid &&
                  (!bus.req0_valid || last_grant_q == LU_ID_REQ0);
    assign accept = gnt0 || gnt1;

    assign bus.req0_ready = gnt0 && !reset;
    assign bus.req1_ready = gnt1 && !reset;

    assign op_a    = gnt1 ? bus.req1_a    : bus.req0_a;
    assign op_b    = gnt1 ? bus.req1_b    : bus.req0_b;
    assign op_nand = gnt1 ? bus.req1_nand : bus.req0_nand;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a_i        (op_a),
        .b_i        (op_b),
        .nand_i     (op_nand),
        .y_o        (unit_y),
        .carryout_o (unit_co),
        .overflow_o (unit_ov)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = unit_y;
            rsp_id_d     = gnt1 ? LU_ID_REQ1 : LU_ID_REQ0;
            last_grant_d = gnt1 ? LU_ID_REQ1 : LU_ID_REQ0;
        end else if (bus.rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= LU_ID_REQ0;
            last_grant_q <= LU_ID_REQ1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_carryout = unit_co;
    assign bus.rsp_overflow = unit_ov;
endmodule
